conv_win_ctrl: RTL and testbench

- Sequencer that drives one conv_eng instance: loads 9 weights, accepts a raster pixel stream and maintains two line buffers.
- Forms each 3x3 window, pulses the engine enable, and returns engine results through a valid/ready output.
- Sits between the pixel source (DMA/stream) and the result sink; owns conv_eng's nums_to_multiply, weights and en inputs.

---
 rtl/conv_win_ctrl_if.sv | 30 +++
 rtl/conv_win_ctrl.sv | 168 ++++++++++++++++
 tb/tb_conv_win_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_win_ctrl_if.sv
// conv_win_ctrl_if: stream/control bundle between the window controller and
// its surroundings (weight source, pixel source, result sink, frame control).
//   master : the environment side (drives start/abort, weights, pixels, res_ready)
//   slave  : the controller side (drives ready signals, results, busy/done)
interface conv_win_ctrl_if;
    logic        start;
    logic        abort;
    logic        wt_valid;
    logic [7:0]  wt_data;
    logic        wt_ready;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_last;
    logic        res_ready;
    logic        busy;
    logic        done;

    modport master (
        output start, abort, wt_valid, wt_data, pix_valid, pix_data, res_ready,
        input  wt_ready, pix_ready, res_valid, res_data, res_last, busy, done
    );

    modport slave (
        input  start, abort, wt_valid, wt_data, pix_valid, pix_data, res_ready,
        output wt_ready, pix_ready, res_valid, res_data, res_last, busy, done
    );
endinterface

// File: rtl/conv_win_ctrl.sv
// conv_win_ctrl: sequences one conv_eng instance over a raster image.
// Loads 9 weights, streams pixels through two line buffers, forms each 3x3
// window, pulses the engine enable and returns engine results via valid/ready.
// Ports:
//   clk, rstn_   : clock, asynchronous active-low reset
//   bus          : control / weight / pixel / result streams (slave side)
//   eng_nums     : 3x3 window to the engine, byte i = row*3 + col
//   eng_weights  : weights to the engine, byte k = k-th weight loaded
//   eng_en       : engine enable, same cycle as the accepting pixel
//   eng_result   : engine result, registered by the engine on eng_en
module conv_win_ctrl #(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic             clk,
    input  logic             rstn_,
    conv_win_ctrl_if.slave   bus,
    output logic [71:0]      eng_nums,
    output logic [71:0]      eng_weights,
    output logic             eng_en,
    input  logic [15:0]      eng_result
);

    localparam int unsigned XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    logic [3:0]      wcnt_q;
    logic            res_valid_q, res_valid_d;
    logic            res_last_q, res_last_d;
    logic            wt_fire, pix_fire, frame_end;

    logic [7:0]      lb1_q [IMG_W];   // row y-1
    logic [7:0]      lb2_q [IMG_W];   // row y-2
    logic [7:0]      col1_q [3];      // column x-1, per window row
    logic [7:0]      col0_q [3];      // column x-2, per window row
    logic [7:0]      cur_c [3];       // column x, straight from buffers/input

    assign wt_fire   = bus.wt_valid & bus.wt_ready;
    assign pix_fire  = bus.pix_valid & bus.pix_ready;
    assign frame_end = (x_q == X_LAST) && (y_q == Y_LAST);
    assign eng_en    = pix_fire && (x_q >= XW'(2)) && (y_q >= YW'(2));

    // State register
    always_ff @(posedge clk or negedge rstn_) begin
        if (!rstn_) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (bus.start)                 state_d = S_LOAD_W;
                S_LOAD_W: if (wt_fire && wcnt_q == 4'd8) state_d = S_RUN;
                S_RUN:    if (pix_fire && frame_end)     state_d = S_DRAIN;
                S_DRAIN:  if (!res_valid_q)              state_d = S_DONE;
                S_DONE:                                  state_d = S_IDLE;
                default:                                 state_d = S_IDLE;
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        bus.wt_ready  = 1'b0;
        bus.pix_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.wt_ready  = (state_q == S_LOAD_W);
        bus.pix_ready = (state_q == S_RUN) && (!res_valid_q || bus.res_ready);
        bus.busy      = (state_q != S_IDLE);
        bus.done      = (state_q == S_DONE);
    end

    // Result handshake: a result appears the cycle after eng_en and is held until taken
    always_comb begin
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        if (bus.abort) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
        end else if (eng_en) begin
            res_valid_d = 1'b1;
            res_last_d  = frame_end;
        end else if (bus.res_ready) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_last  = res_last_q;
    assign bus.res_data  = eng_result;

    // Counters, weight slots and result flags
    always_ff @(posedge clk or negedge rstn_) begin
        if (!rstn_) begin
            x_q         <= '0;
            y_q         <= '0;
            wcnt_q      <= '0;
            eng_weights <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            if (state_q == S_IDLE && bus.start && !bus.abort) begin
                x_q    <= '0;
                y_q    <= '0;
                wcnt_q <= '0;
            end
            if (wt_fire) begin
                eng_weights[{wcnt_q, 3'b000} +: 8] <= bus.wt_data;
                wcnt_q <= wcnt_q + 4'd1;
            end
            if (pix_fire) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    // Line buffers and window column shift registers (contents don't-care at reset)
    always_ff @(posedge clk) begin
        if (pix_fire) begin
            lb2_q[x_q] <= lb1_q[x_q];
            lb1_q[x_q] <= bus.pix_data;
            for (int r = 0; r < 3; r++) begin
                col1_q[r] <= cur_c[r];
                col0_q[r] <= col1_q[r];
            end
        end
    end

    // Window assembly: row 0 is the oldest line, column 2 is the incoming pixel's column
    always_comb begin
        cur_c[0] = lb2_q[x_q];
        cur_c[1] = lb1_q[x_q];
        cur_c[2] = bus.pix_data;
        eng_nums = '0;
        for (int r = 0; r < 3; r++) begin
            eng_nums[8*(3*r + 0) +: 8] = col0_q[r];
            eng_nums[8*(3*r + 1) +: 8] = col1_q[r];
            eng_nums[8*(3*r + 2) +: 8] = cur_c[r];
        end
    end

endmodule

// File: tb/tb_conv_win_ctrl.sv
// tb_conv_win_ctrl: randomized scoreboard bench for conv_win_ctrl with a
// behavioural conv_eng and a frame-level reference convolution model.
module tb_conv_win_ctrl;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 4;
    localparam int unsigned NPIX = W * H;

    logic        clk = 1'b0;
    logic        rstn_;
    logic [71:0] eng_nums;
    logic [71:0] eng_weights;
    logic        eng_en;
    logic [15:0] eng_result = '0;

    always #5 clk = ~clk;

    conv_win_ctrl_if ifc ();

    conv_win_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk         (clk),
        .rstn_       (rstn_),
        .bus         (ifc.slave),
        .eng_nums    (eng_nums),
        .eng_weights (eng_weights),
        .eng_en      (eng_en),
        .eng_result  (eng_result)
    );

    // Behavioural conv_eng: sum of 8x8 products, everything mod 2^16, registered on en
    function automatic logic [15:0] eng_calc(input logic [71:0] n, input logic [71:0] w);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 9; i++) s = s + 16'(16'(n[8*i +: 8]) * 16'(w[8*i +: 8]));
        return s;
    endfunction

    always @(posedge clk) if (eng_en) eng_result <= eng_calc(eng_nums, eng_weights);

    int          nvec = 0;
    int          nmis = 0;
    int          done_cnt = 0;
    int          rr_mode = 0;
    logic [16:0] exp_q [$];
    logic [7:0]  w_arr [9];
    logic [7:0]  img [NPIX];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: direct 3x3 convolution over the stored frame, valid windows only
    task automatic push_expected();
        int sum;
        for (int y = 2; y < int'(H); y++) begin
            for (int x = 2; x < int'(W); x++) begin
                sum = 0;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        sum += int'(img[(y-2+r)*W + (x-2+c)]) * int'(w_arr[r*3+c]);
                exp_q.push_back({(y == int'(H)-1 && x == int'(W)-1), 16'(sum)});
            end
        end
    endtask

    // Sink ready driver: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random
    initial begin
        logic pat [4];
        int   ph;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        ph = 0;
        ifc.res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                1:       begin ifc.res_ready = pat[ph]; ph = (ph + 1) % 4; end
                2:       ifc.res_ready = 1'($urandom_range(0, 1));
                default: ifc.res_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every result handshake
    initial begin
        logic [16:0] e;
        logic        prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn_ === 1'b1) begin
                if (ifc.res_valid && ifc.res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'(ifc.res_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", 32'(ifc.res_data), 32'(e[15:0]));
                        check("res_last", 32'(ifc.res_last), 32'(e[16]));
                    end
                end
                if (ifc.res_valid && !ifc.res_ready)
                    check("pix_ready_stall", 32'(ifc.pix_ready), 32'd0);
                if (ifc.done) done_cnt++;
                if (prev_done && !ifc.done)
                    check("busy_at_done_fall", 32'(ifc.busy), 32'd0);
                prev_done = ifc.done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(posedge clk); #1;
        ifc.start = 1'b0;
    endtask

    task automatic send_wt(input logic [7:0] b);
        int n;
        ifc.wt_valid = 1'b1;
        ifc.wt_data  = b;
        n = 0;
        forever begin
            @(negedge clk);
            if (ifc.wt_ready) break;
            n++;
            if (n > 50) begin
                check("wt_ready_timeout", 32'(ifc.wt_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        ifc.wt_valid = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] p);
        int n;
        ifc.pix_valid = 1'b1;
        ifc.pix_data  = p;
        n = 0;
        forever begin
            @(negedge clk);
            if (ifc.pix_ready) break;
            n++;
            if (n > 100) begin
                check("pix_ready_timeout", 32'(ifc.pix_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        ifc.pix_valid = 1'b0;
    endtask

    // One frame; optional start pulse mid-RUN and optional reset after rst_after pixels
    task automatic do_frame(input int start_mid, input int rst_after, input int gap_max);
        int n;
        done_cnt = 0;
        pulse_start();
        for (int k = 0; k < 9; k++) send_wt(w_arr[k]);
        push_expected();
        for (int p = 0; p < int'(NPIX); p++) begin
            if (p == rst_after) begin
                check("busy_in_run", 32'(ifc.busy), 32'd1);
                ifc.pix_valid = 1'b1;
                ifc.pix_data  = img[p];
                rstn_ = 1'b0;
                #1;
                check("rst_busy", 32'(ifc.busy), 32'd0);
                check("rst_res_valid", 32'(ifc.res_valid), 32'd0);
                check("rst_eng_en", 32'(eng_en), 32'd0);
                ifc.pix_valid = 1'b0;
                exp_q.delete();
                @(posedge clk); #1;
                rstn_ = 1'b1;
                @(posedge clk); #1;
                return;
            end
            if (p == start_mid) pulse_start();
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            send_pix(img[p]);
        end
        n = 0;
        while (!ifc.done && n < 300) begin @(negedge clk); n++; end
        if (!ifc.done) check("done_timeout", 32'(ifc.done), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("results_left", 32'(exp_q.size()), 32'd0);
        check("busy_idle", 32'(ifc.busy), 32'd0);
    endtask

    task automatic rand_frame_data();
        for (int k = 0; k < 9; k++) w_arr[k] = 8'($urandom_range(0, 255));
        for (int p = 0; p < int'(NPIX); p++) img[p] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.start     = 1'b0;
        ifc.abort     = 1'b0;
        ifc.wt_valid  = 1'b0;
        ifc.wt_data   = '0;
        ifc.pix_valid = 1'b0;
        ifc.pix_data  = '0;
        rstn_         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy0", 32'(ifc.busy), 32'd0);
        check("rst_res_valid0", 32'(ifc.res_valid), 32'd0);
        check("rst_res_last0", 32'(ifc.res_last), 32'd0);
        check("rst_done0", 32'(ifc.done), 32'd0);
        check("rst_eng_en0", 32'(eng_en), 32'd0);
        check("rst_wt_ready0", 32'(ifc.wt_ready), 32'd0);
        check("rst_weights0", 32'(eng_weights[31:0] | eng_weights[63:32] | 32'(eng_weights[71:64])), 32'd0);
        rstn_ = 1'b1;
        @(posedge clk); #1;

        // all ones -> four results of 9
        rr_mode = 0;
        for (int k = 0; k < 9; k++) w_arr[k] = 8'd1;
        for (int p = 0; p < int'(NPIX); p++) img[p] = 8'd1;
        do_frame(-1, -1, 0);

        // centre tap only, ramp image -> 5, 6, 9, 10
        for (int k = 0; k < 9; k++) w_arr[k] = (k == 4) ? 8'd1 : 8'd0;
        for (int p = 0; p < int'(NPIX); p++) img[p] = 8'(p);
        do_frame(-1, -1, 0);

        // same with 1-0-0-1 sink backpressure
        rr_mode = 1;
        do_frame(-1, -1, 0);

        // saturated operands -> 60937 each
        rr_mode = 0;
        for (int k = 0; k < 9; k++) w_arr[k] = 8'hFF;
        for (int p = 0; p < int'(NPIX); p++) img[p] = 8'hFF;
        do_frame(-1, -1, 0);

        // reset after 7 pixels, then a full frame
        rr_mode = 2;
        rand_frame_data();
        do_frame(-1, 7, 1);
        rand_frame_data();
        do_frame(-1, -1, 2);

        // start during RUN is ignored
        rr_mode = 0;
        rand_frame_data();
        do_frame(5, -1, 0);

        // abort in LOAD_W, then a full reload and frame
        done_cnt = 0;
        rand_frame_data();
        pulse_start();
        for (int k = 0; k < 4; k++) send_wt(w_arr[k]);
        check("wt_ready_in_load", 32'(ifc.wt_ready), 32'd1);
        ifc.abort = 1'b1;
        @(posedge clk); #1;
        ifc.abort = 1'b0;
        check("abort_busy", 32'(ifc.busy), 32'd0);
        check("abort_wt_ready", 32'(ifc.wt_ready), 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        do_frame(-1, -1, 1);

        // random frames with random gaps and backpressure
        rr_mode = 2;
        for (int f = 0; f < 4; f++) begin
            rand_frame_data();
            do_frame(-1, -1, 3);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
